// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NUM_REQ requesters.
// Optional subtract mode is enabled by defining ADD_ARBITER_SUB_EN.
module add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH = 8,
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
`ifdef ADD_ARBITER_SUB_EN
  input  logic [NUM_REQ-1:0]         req_sub,
`endif
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [WIDTH:0]             rsp_sum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  grant;
  logic             found;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [ID_W-1:0]  op_id;
  logic             op_sub;
  logic             accept;

  // Cyclic search starting just after the previous grantee.
  always_comb begin
    int idx;
    idx = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(last) + 1 + k) % NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  assign accept = (state == IDLE) && found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= ID_W'(NUM_REQ - 1);
      op_a      <= '0;
      op_b      <= '0;
      op_id     <= '0;
      op_sub    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= req_a[grant*WIDTH +: WIDTH];
            op_b  <= req_b[grant*WIDTH +: WIDTH];
            op_id <= grant;
`ifdef ADD_ARBITER_SUB_EN
            op_sub <= req_sub[grant];
`else
            op_sub <= 1'b0;
`endif
            last  <= grant;
            state <= CALC;
          end
        end
        CALC: begin
          if (op_sub)
            rsp_sum <= {1'b0, op_a} - {1'b0, op_b};
          else
            rsp_sum <= {1'b0, op_a} + {1'b0, op_b};
          rsp_id    <= op_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed self-checking bench for add_arbiter.
// Define ADD_ARBITER_SUB_EN to also exercise subtract mode.
module tb_add_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_sub;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W:0]     rsp_sum;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_a(req_a),
    .req_b(req_b),
`ifdef ADD_ARBITER_SUB_EN
    .req_sub(req_sub),
`endif
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_sum(rsp_sum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    #1;
  endtask

  task automatic test_reset();
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_sum !== 9'h000) begin
      failures++;
      $display("FAIL reset_rsp got v=%b id=%0d sum=%h exp 0/0/000",
               rsp_valid, rsp_id, rsp_sum);
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    set_op(1, 8'hF0, 8'h20);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0010", req_ready);
    end
    tick();
    req_valid = '0;
    set_op(1, 8'h00, 8'h00);
    checks++;
    if (req_ready !== 4'b0000 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_calc got ready=%b v=%b exp 0000/0",
               req_ready, rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 9'h110 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL single_rsp got v=%b sum=%h id=%0d exp 1/110/1",
               rsp_valid, rsp_sum, rsp_id);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 9'h110 || rsp_id !== 2'd1) begin
      failures++;
      $display("FAIL single_done got v=%b sum=%h id=%0d exp 0/110/1",
               rsp_valid, rsp_sum, rsp_id);
    end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_op(2, 8'h7F, 8'h01);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bp_grant got=%b exp=0100", req_ready);
    end
    tick();
    req_valid = 4'b0001;
    tick();
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 9'h080 || rsp_id !== 2'd2 ||
          req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_hold c=%0d got v=%b sum=%h id=%0d rdy=%b exp 1/080/2/0000",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    set_op(0, 8'h12, 8'h34);
    #1;
    checks++;
    if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_last got v=%b rdy=%b exp 1/0000", rsp_valid, req_ready);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_next got v=%b rdy=%b exp 0/0001", rsp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 9'h046 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_pre got v=%b sum=%h id=%0d exp 1/046/0",
               rsp_valid, rsp_sum, rsp_id);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_sum !== 9'h000 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_async got v=%b sum=%h id=%0d exp 0/000/0",
               rsp_valid, rsp_sum, rsp_id);
    end
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [W:0] exp_sum [4];
    exp_sum = '{9'h101, 9'h112, 9'h123, 9'h134};
    for (int i = 0; i < N; i++) set_op(i, W'(8'h11 * (i + 1)), 8'hF0);
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++;
        $display("FAIL rr_grant k=%0d got=%b exp=%b", k, req_ready,
                 4'(1 << (k % 4)));
      end
      tick();
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(k % 4) ||
          rsp_sum !== exp_sum[k % 4]) begin
        failures++;
        $display("FAIL rr_rsp k=%0d got v=%b id=%0d sum=%h exp 1/%0d/%h",
                 k, rsp_valid, rsp_id, rsp_sum, k % 4, exp_sum[k % 4]);
      end
      tick();
    end
    req_valid = '0;
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    req_valid = 4'b1000;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL wrap_pre got=%b exp=1000", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    tick();
    set_op(0, 8'hFF, 8'hFF);
    set_op(3, 8'h01, 8'h01);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_sum !== 9'h1FE || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL wrap_rsp got v=%b sum=%h id=%0d exp 1/1FE/0",
               rsp_valid, rsp_sum, rsp_id);
    end
    tick();
  endtask

  task automatic test_same_again();
    rsp_ready = 1'b1;
    set_op(0, 8'h80, 8'h80);
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL again_grant got=%b exp=0001", req_ready);
    end
    tick();
    req_valid = '0;
    tick();
    checks++;
    if (rsp_sum !== 9'h100 || rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL again_rsp got sum=%h id=%0d exp 100/0", rsp_sum, rsp_id);
    end
    tick();
  endtask

`ifdef ADD_ARBITER_SUB_EN
  task automatic test_sub();
    rsp_ready = 1'b1;
    for (int s = 1; s >= 0; s--) begin
      set_op(0, 8'h05, 8'h07);
      req_sub = 4'(s);
      req_valid = 4'b0001;
      tick();
      req_valid = '0;
      req_sub = '0;
      tick();
      checks++;
      if (rsp_sum !== (s == 1 ? 9'h1FE : 9'h00C)) begin
        failures++;
        $display("FAIL sub s=%0d got sum=%h exp %h", s, rsp_sum,
                 (s == 1 ? 9'h1FE : 9'h00C));
      end
      tick();
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_sub = '0;
    rsp_ready = 1'b0;
    #12;
    test_reset();
    tick();
    rst = 1'b0;
    tick();
    test_single();
    test_backpressure();
    test_reset_mid();
    test_round_robin();
    test_wrap();
    test_same_again();
`ifdef ADD_ARBITER_SUB_EN
    test_sub();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
Name: add_arbiter

Overview:
- Shares one registered WIDTH-bit adder between NUM_REQ requesters, e.g. switch banks, a debug port and the core.
- Round-robin grant with a valid/ready request handshake per requester.
- Single response channel carrying the sum with carry-out and the ID of the served requester.
- Sits between the board-I/O front end and the LED/display sink.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 8, operand width in bits.
- ID_W, derived, $clog2(NUM_REQ), minimum 1; not user-overridable.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_a  input  NUM_REQ*WIDTH  operand A; requester i uses bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot accept strobe.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  sink accepts the response.
- rsp_id  output  ID_W  index of the served requester.
- rsp_sum  output  WIDTH+1  A+B; MSB is the carry-out.

Behaviour:
- Reset (async, rst=1): state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_sum=0, last-grant pointer=NUM_REQ-1 so requester 0 has first priority. Asynchronous assertion mid-operation drops any in-flight request or response with no output.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - If any req_valid, grant g = first requester with req_valid set, searching cyclically from (last+1) mod NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits 0.
  - On the clock edge: latch req_a[g], req_b[g] and g; set last=g; go to CALC.
  - No req_valid: stay in IDLE with req_ready=0.
- CALC: register rsp_sum = {1'b0,A} + {1'b0,B} (full WIDTH+1 result, no truncation) and rsp_id=g; set rsp_valid=1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_sum and rsp_id stable until rsp_ready=1.
  - On rsp_valid & rsp_ready: clear rsp_valid and go to IDLE.
  - rsp_sum and rsp_id keep their last value after rsp_valid clears.
- req_ready is 0 in CALC and RESP; requests are never accepted there.
- Latency: acceptance at edge N, rsp_valid=1 after edge N+1; minimum 3 cycles per transaction when rsp_ready is held high.
- Requester rules:
  - Operands are sampled only in the accept cycle and may change afterwards.
  - A requester keeps req_valid asserted until it sees req_ready; dropping it earlier is legal and simply forfeits the slot.
- Fairness: with all NUM_REQ requesters continuously valid, grants rotate 0,1,2,...,NUM_REQ-1,0; no starvation.
- Wrap-around: pointer at NUM_REQ-1 searches from 0.
- Only requester = last grantee: it is granted again.
- Simultaneous rsp_ready and a new req_valid in RESP: the response completes this cycle; the new request is granted next cycle in IDLE.

Optional Feature:
- Macro ADD_ARBITER_SUB_EN.
- Defined:
  - Adds input port req_sub (NUM_REQ bits), sampled with the operands in the accept cycle.
  - When the granted bit is 1, rsp_sum = {1'b0,A} - {1'b0,B} truncated to WIDTH+1 bits (MSB=1 indicates borrow).
  - When the bit is 0, rsp_sum is the add result.
- Undefined: port absent; always add; no extra logic.

Test Plan:
- Reset: assert rst mid-RESP with rsp_valid=1 -> outputs go to 0 immediately without waiting for clk; first grant after release goes to requester 0.
- Single request: req_valid=4'b0010, A=8'hF0, B=8'h20, rsp_ready=1 -> req_ready=4'b0010 for one cycle; two edges later rsp_valid=1, rsp_sum=9'h110, rsp_id=1.
- Round robin: req_valid=4'b1111 held, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0; one transaction every 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles with A=8'h7F, B=8'h01 -> rsp_sum=9'h080 and rsp_id stable throughout; req_ready=0 while waiting; completes on the first cycle rsp_ready=1.
- Max operands and wrap: last grant=3, req_valid=4'b1001, A=B=8'hFF -> grant to requester 0, rsp_sum=9'h1FE.
- ADD_ARBITER_SUB_EN defined: req_sub=1, A=8'h05, B=8'h07 -> rsp_sum=9'h1FE; same request with req_sub=0 -> rsp_sum=9'h00C.
